// File: rtl/bsh_32_ctrl.sv
// Multi-pass shift controller around a 32-bit barrel shifter.
// Commands in via valid/ready, result out via valid/ready.
module bsh_32 (
  input  logic [31:0] data_in,
  input  logic        dir,
  input  logic [4:0]  sh,
  output logic [31:0] data_out
);

  // Logical shift, zero fill; dir=1 shifts right
  always_comb begin
    data_out = dir ? (data_in >> sh) : (data_in << sh);
  end

endmodule

module bsh_32_ctrl #(
  parameter int AMT_W    = 8,
  parameter int MAX_STEP = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_dir,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic [AMT_W-1:0] pass_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      acc_q;
  logic             dir_q;
  logic [AMT_W-1:0] rem_q;
  logic [AMT_W-1:0] pass_q;
  logic [4:0]       step;
  logic [AMT_W-1:0] rem_next;
  logic [31:0]      shifted;

  // Clamp each pass to the 5-bit shifter range
  always_comb begin
    step     = (rem_q > AMT_W'(MAX_STEP)) ? 5'(MAX_STEP) : rem_q[4:0];
    rem_next = rem_q - AMT_W'(step);
  end

  bsh_32 u_bsh (
    .data_in  (acc_q),
    .dir      (dir_q),
    .sh       (step),
    .data_out (shifted)
  );

  // Handshake flags derive from state only
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    pass_cnt = pass_q;
  end

  // Control FSM with datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_q     <= '0;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      pass_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc_q  <= in_data;
            dir_q  <= in_dir;
            rem_q  <= in_amt;
            pass_q <= '0;
            state  <= (in_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc_q  <= shifted;
          rem_q  <= rem_next;
          pass_q <= pass_q + 1'b1;
          if (rem_next == '0) state <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsh_32_ctrl.sv
// Directed self-checking bench for bsh_32_ctrl.
// Each task drives one scenario and checks inline.
module tb_bsh_32_ctrl;

  localparam int AMT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_dir;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;
  logic [AMT_W-1:0] pass_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bsh_32_ctrl #(.AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .pass_cnt  (pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_dir = 1'b0;
    in_amt = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out_data got %h want 0", out_data);
    end
    n_cmp++;
    if (pass_cnt !== '0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pass_busy got %0d/%b want 0/0",
               pass_cnt, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one command, wait for result with out_ready high,
  // check latency, data, pass count and the handoff.
  task automatic run_cmd(input string nm,
                         input logic [31:0] d,
                         input logic dr,
                         input logic [AMT_W-1:0] a,
                         input logic [31:0] exp_d,
                         input int exp_p,
                         input int exp_lat);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready got %b want 1", nm, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_dir = dr;
    in_amt = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (n !== exp_lat) begin
      n_bad++;
      $display("FAIL %s_latency got %0d want %0d", nm, n, exp_lat);
    end
    n_cmp++;
    if (out_data !== exp_d) begin
      n_bad++;
      $display("FAIL %s_data got %h want %h", nm, out_data, exp_d);
    end
    n_cmp++;
    if (pass_cnt !== AMT_W'(exp_p)) begin
      n_bad++;
      $display("FAIL %s_pass got %0d want %0d", nm, pass_cnt, exp_p);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_handoff got v=%b r=%b want v=0 r=1",
               nm, out_valid, in_ready);
    end
    n_cmp++;
    if (pass_cnt !== AMT_W'(exp_p)) begin
      n_bad++;
      $display("FAIL %s_pass_hold got %0d want %0d",
               nm, pass_cnt, exp_p);
    end
  endtask

  task automatic test_single_pass;
    run_cmd("l1", 32'h8000_0001, 1'b0, 8'd1, 32'h0000_0002, 1, 2);
    run_cmd("r31", 32'hFFFF_FFFF, 1'b1, 8'd31, 32'h0000_0001, 1, 2);
  endtask

  task automatic test_multi_pass;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'h0000_0001;
    in_dir = 1'b0;
    in_amt = 8'd40;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dut.acc_q !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL l40_pass1 got %h want 80000000", dut.acc_q);
    end
    repeat (4) @(posedge clk);
    #1;
    run_cmd("l40", 32'h0000_0001, 1'b0, 8'd40, 32'h0, 2, 3);
    run_cmd("r33", 32'hFFFF_FFFF, 1'b1, 8'd33, 32'h0, 2, 3);
    run_cmd("l200", 32'hFFFF_FFFF, 1'b0, 8'd200, 32'h0, 7, 8);
  endtask

  task automatic test_zero_amt;
    run_cmd("z0", 32'h1234_5678, 1'b1, 8'd0, 32'h1234_5678, 0, 1);
  endtask

  task automatic test_stall;
    int n;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h0000_00F0;
    in_dir = 1'b1;
    in_amt = 8'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_valid got %b want 1", out_valid);
    end
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    in_amt = 8'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_000F
          || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d got v=%b d=%h r=%b want 1/f/0",
                 i, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release got v=%b r=%b want 0/1",
               out_valid, in_ready);
    end
    n = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    n_cmp++;
    if (n !== 0) begin
      n_bad++;
      $display("FAIL stall_extra got %0d want 0", n);
    end
  endtask

  task automatic test_back_to_back;
    run_cmd("b2b_a", 32'h0000_000F, 1'b0, 8'd8, 32'h0000_0F00, 1, 2);
    run_cmd("b2b_b", 32'h0000_0001, 1'b0, 8'd35, 32'h0, 2, 3);
    run_cmd("b2b_c", 32'hA5A5_0000, 1'b1, 8'd16, 32'h0000_A5A5, 1, 2);
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    in_dir = 1'b0;
    in_amt = 8'd200;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || pass_cnt !== '0) begin
      n_bad++;
      $display("FAIL rstmid got r=%b b=%b p=%0d want 1/0/0",
               in_ready, busy, pass_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    n_cmp++;
    if (n !== 0) begin
      n_bad++;
      $display("FAIL rstmid_no_out got %0d want 0", n);
    end
  endtask

  initial begin
    test_reset;
    test_single_pass;
    test_multi_pass;
    test_zero_amt;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    run_cmd("post_rst", 32'h0000_0003, 1'b0, 8'd2, 32'h0000_000C, 1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bsh_32_ctrl.md
Name: bsh_32_ctrl

Overview:
Multi-pass shift controller wrapped around one bsh_32 combinational barrel shifter. It accepts a shift command through a valid/ready handshake. A command carries a 32-bit operand, a direction and a shift amount up to 2^AMT_W-1. The controller registers the command and feeds the operand through bsh_32 repeatedly, at most 31 positions per pass, then presents the result on a valid/ready output. It is the control and datapath-register stage both upstream (drives data_in/dir/sh) and downstream (captures data_out) of bsh_32.

Parameters:
AMT_W, 8, width of requested shift amount; legal range 6..16
MAX_STEP, 31, maximum shift per pass; fixed to 31 because bsh_32 sh is 5 bits; not to be overridden

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  command valid
in_ready  output  1  controller can accept command
in_data  input  32  operand
in_dir  input  1  direction; 0 = logical left, 1 = logical right (bsh_32 convention, zero fill)
in_amt  input  AMT_W  total shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  32  shifted result
busy  output  1  high in SHIFT or DONE
pass_cnt  output  AMT_W  passes used by the current or last command

Behaviour:
- One bsh_32 instance inside. Its data_in is acc_q, its dir is dir_q, and its sh is step.
- Registers: acc_q[31:0], dir_q, rem_q[AMT_W-1:0], pass_q.
- step = (rem_q > 31) ? 31 : rem_q[4:0]. A pass never exceeds 31, so sh never wraps.
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: in_ready=1 (in IDLE), out_valid=0, out_data=0, busy=0, pass_cnt=0, acc_q=0, rem_q=0.
- IDLE:
  - in_ready=1.
  - On in_valid: load acc_q=in_data, dir_q=in_dir, rem_q=in_amt, pass_q=0.
  - Go to DONE if in_amt==0, else go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: acc_q <= bsh_32.data_out, rem_q <= rem_q - step, pass_q <= pass_q + 1.
  - Go to DONE when rem_q - step == 0.
  - Number of SHIFT cycles = ceil(in_amt/31).
- DONE:
  - out_valid=1 and out_data=acc_q. Both are held stable while out_ready=0.
  - When out_valid && out_ready, go to IDLE. out_valid drops in the next cycle.
  - No new command is accepted in the handoff cycle.
- Latency: command accepted at edge k. out_valid is first high after edge k+ceil(in_amt/31)+1. For amt=0 that is edge k+1.
- pass_cnt = pass_q. It holds its value after DONE until the next command is accepted.
- Amounts ≥ 32 produce 0, reached naturally by iteration; there is no shortcut. in_dir has no effect when in_amt==0.
- in_valid while in_ready=0 is ignored. The upstream side holds its command per handshake rules.
- Asynchronous rst in any state: immediate return to IDLE with reset values. The in-flight command is discarded and no out_valid is emitted for it.
- The handshake is ready-independent: in_ready and out_valid never depend combinationally on in_valid or out_ready.

Test Plan:
- Reset → in_ready=1, out_valid=0, out_data=0x0000_0000, pass_cnt=0; assert rst mid-SHIFT → IDLE next, no out_valid.
- in_data=0x8000_0001, dir=0, amt=1, out_ready=1 → out_data=0x0000_0002, pass_cnt=1, out_valid at edge k+2.
- in_data=0x0000_0001, dir=0, amt=40 → passes 31 then 9: 0x8000_0000 then 0x0000_0000; pass_cnt=2, out_valid at k+3.
- in_data=0xFFFF_FFFF, dir=1, amt=33 → 0x0000_0001 after pass 1, then 0x0000_0000; pass_cnt=2; amt=31 right on 0xFFFF_FFFF → 0x0000_0001, pass_cnt=1.
- amt=0, in_data=0x1234_5678 → out_data=0x1234_5678, pass_cnt=0, out_valid at k+1.
- out_ready held low 5 cycles in DONE → out_valid and out_data stable, in_ready=0, new in_valid ignored; out_ready=1 → IDLE next cycle; back-to-back commands each produce exactly one result.
